// File: rtl/pulse_txrx_sequencer.sv
// -----------------------------------------------------------------------------
// pulse_txrx_sequencer
//   Sequencer for one transceiver of the pulse-propagation meter. It brings up
//   the DAC once after reset. It then runs one of two modes:
//     - initiator bursts: TX pulse, receive window, coarse RTT, timeout
//     - responder echoes: listen for a pulse, wait, transmit a reply
//   It also drives the antenna/amplifier switching and the TDC START/STOP gating.
//
//   Optional feature (macro BURST_RETRY_EN):
//     A receive timeout counts a miss in o_MissCnt and the burst carries on.
//     Without the macro a timeout aborts the burst, and o_MissCnt is absent.
//
// Ports
//   i_Clk, i_Rst_L     clock, async active-low reset
//   i_Mode             1 = initiator, 0 = responder (sampled in IDLE/LISTEN)
//   i_Start            burst request (IDLE only)
//   i_BurstLen         measurements per burst, 0 -> 1
//   i_Rx               raw received-pulse line
//   i_DacReady         DAC SPI master done
//   o_DacStart         1-cycle DAC configuration request
//   o_TxPulse          transmit pulse
//   o_TdcStart         copy of o_TxPulse
//   o_TdcStop          i_Rx gated by the receive-window arm flop
//   o_AntTx, o_AntRx, o_EnAmp, o_EnRxPwr, o_EnLna   front-end controls
//   o_Busy             measurement/reply sequence in progress
//   o_Rtt, o_RttValid  captured coarse RTT and its strobe
//   o_MeasIdx          0-based measurement index
//   o_Done, o_Timeout  end-of-burst / end-of-reply and timeout strobes
//   o_MissCnt          (BURST_RETRY_EN only) timeouts seen this burst
// -----------------------------------------------------------------------------
module pulse_txrx_sequencer #(
  parameter int PULSE_CYCLES      = 4,
  parameter int GUARD_CYCLES      = 8,
  parameter int RESP_DELAY_CYCLES = 8,
  parameter int TIMEOUT_CYCLES    = 1000,
  parameter int BURST_W           = 8,
  parameter int CNT_W             = 16
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Mode,
  input  logic               i_Start,
  input  logic [BURST_W-1:0] i_BurstLen,
  input  logic               i_Rx,
  input  logic               i_DacReady,
  output logic               o_DacStart,
  output logic               o_TxPulse,
  output logic               o_TdcStart,
  output logic               o_TdcStop,
  output logic               o_AntTx,
  output logic               o_AntRx,
  output logic               o_EnAmp,
  output logic               o_EnRxPwr,
  output logic               o_EnLna,
  output logic               o_Busy,
  output logic [CNT_W-1:0]   o_Rtt,
  output logic               o_RttValid,
  output logic [BURST_W-1:0] o_MeasIdx,
  output logic               o_Done,
`ifdef BURST_RETRY_EN
  output logic [BURST_W-1:0] o_MissCnt,
`endif
  output logic               o_Timeout
);

  localparam int TMR_MAX = (PULSE_CYCLES > GUARD_CYCLES)
                         ? ((PULSE_CYCLES > RESP_DELAY_CYCLES) ? PULSE_CYCLES : RESP_DELAY_CYCLES)
                         : ((GUARD_CYCLES > RESP_DELAY_CYCLES) ? GUARD_CYCLES : RESP_DELAY_CYCLES);
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  typedef enum logic [3:0] {
    S_INIT_DAC, S_WAIT_DAC, S_IDLE, S_LISTEN,
    S_TX_GUARD, S_TX_PULSE, S_RX_GUARD, S_RX_WAIT, S_RESP_DELAY
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;        // cycles spent in current state
  logic [CNT_W-1:0]   cnt_q, cnt_d;        // RTT counter, 0 on first TX_PULSE cycle
  logic [BURST_W-1:0] blen_q, blen_d;
  logic [BURST_W-1:0] idx_q, idx_d;
  logic               role_q, role_d;      // 1: current sequence belongs to an initiator burst
  logic               seen_rise_q, seen_rise_d;
  logic               stop_arm_q;
  logic               rx_s1_q, rx_s2_q, rx_s3_q;
  logic               dac_start_q, dac_start_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               rtt_valid_q, rtt_valid_d;
  logic [CNT_W-1:0]   rtt_q, rtt_d;
`ifdef BURST_RETRY_EN
  logic [BURST_W-1:0] miss_q, miss_d;
`endif

  logic        rx_rise, rx_fall;
  logic        last_meas, rx_timeout;
  logic        pulse_end, guard_end, resp_end;
  logic [31:0] tmr_ext;

  // Edges are taken on the synchronised line; rx_s3_q is only the edge-detect history.
  assign rx_rise = rx_s2_q & ~rx_s3_q;
  assign rx_fall = ~rx_s2_q & rx_s3_q;

  assign tmr_ext   = 32'(tmr_q);
  assign pulse_end = (tmr_ext + 32'd1) >= 32'(PULSE_CYCLES);
  assign guard_end = (tmr_ext + 32'd1) >= 32'(GUARD_CYCLES);
  assign resp_end  = (tmr_ext + 32'd1) >= 32'(RESP_DELAY_CYCLES);

  assign last_meas  = ({1'b0, idx_q} + {{BURST_W{1'b0}}, 1'b1}) >= {1'b0, blen_q};
  assign rx_timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // ---------------------------------------------------------------------------
  // State / datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= S_INIT_DAC;
      tmr_q       <= '0;
      cnt_q       <= '0;
      blen_q      <= '0;
      idx_q       <= '0;
      role_q      <= 1'b0;
      seen_rise_q <= 1'b0;
      stop_arm_q  <= 1'b0;
      rx_s1_q     <= 1'b0;
      rx_s2_q     <= 1'b0;
      rx_s3_q     <= 1'b0;
      dac_start_q <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      rtt_valid_q <= 1'b0;
      rtt_q       <= '0;
`ifdef BURST_RETRY_EN
      miss_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      cnt_q       <= cnt_d;
      blen_q      <= blen_d;
      idx_q       <= idx_d;
      role_q      <= role_d;
      seen_rise_q <= seen_rise_d;
      stop_arm_q  <= (state_d == S_RX_WAIT);
      rx_s1_q     <= i_Rx;
      rx_s2_q     <= rx_s1_q;
      rx_s3_q     <= rx_s2_q;
      dac_start_q <= dac_start_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      rtt_valid_q <= rtt_valid_d;
      rtt_q       <= rtt_d;
`ifdef BURST_RETRY_EN
      miss_q      <= miss_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    blen_d      = blen_q;
    idx_d       = idx_q;
    role_d      = role_q;
    dac_start_d = 1'b0;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    rtt_valid_d = 1'b0;
    rtt_d       = rtt_q;
`ifdef BURST_RETRY_EN
    miss_d      = miss_q;
`endif
    // a pulse counts only if its rising edge was seen while listening
    seen_rise_d = (state_q == S_LISTEN) && (rx_rise || (seen_rise_q && !rx_fall));

    case (state_q)
      S_INIT_DAC: begin
        dac_start_d = 1'b1;
        state_d     = S_WAIT_DAC;
      end
      S_WAIT_DAC: if (i_DacReady) state_d = i_Mode ? S_IDLE : S_LISTEN;
      S_IDLE: begin
        if (!i_Mode) begin
          state_d = S_LISTEN;
        end else if (i_Start) begin
          blen_d  = (i_BurstLen == '0) ? BURST_W'(1) : i_BurstLen;
          idx_d   = '0;
          role_d  = 1'b1;
`ifdef BURST_RETRY_EN
          miss_d  = '0;
`endif
          state_d = S_TX_GUARD;
        end
      end
      S_LISTEN: begin
        if (seen_rise_q && rx_fall) begin
          role_d  = 1'b0;
          state_d = S_RESP_DELAY;
        end else if (i_Mode && !seen_rise_q && !rx_rise) begin
          state_d = S_IDLE;
        end
      end
      S_RESP_DELAY: if (resp_end)  state_d = S_TX_GUARD;
      S_TX_GUARD:   if (guard_end) state_d = S_TX_PULSE;
      S_TX_PULSE:   if (pulse_end) state_d = S_RX_GUARD;
      S_RX_GUARD: begin
        if (guard_end) begin
          if (role_q) begin
            state_d = S_RX_WAIT;
          end else begin
            state_d = S_LISTEN;
            done_d  = 1'b1;
          end
        end
      end
      S_RX_WAIT: begin
        // an edge on the timeout cycle still counts as a hit
        if (rx_rise || rx_timeout) begin
          if (rx_rise) begin
            rtt_valid_d = 1'b1;
            rtt_d       = cnt_q;
          end else begin
            timeout_d   = 1'b1;
`ifdef BURST_RETRY_EN
            miss_d      = (miss_q == '1) ? miss_q : miss_q + 1'b1;
`endif
          end
`ifndef BURST_RETRY_EN
          if (!rx_rise) begin
            state_d = S_IDLE;
          end else
`endif
          if (!last_meas) begin
            idx_d   = idx_q + 1'b1;
            state_d = S_TX_GUARD;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_INIT_DAC;
    endcase

    tmr_d = (state_d != state_q) ? '0 : tmr_q + 1'b1;
    if (state_d == S_TX_PULSE && state_q != S_TX_PULSE) cnt_d = '0;
    else if (cnt_q == '1)                                cnt_d = cnt_q;
    else                                                 cnt_d = cnt_q + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Front-end decode (Moore, so reset drops these asynchronously)
  // ---------------------------------------------------------------------------
  always_comb begin
    o_AntTx   = 1'b0;
    o_EnAmp   = 1'b0;
    o_AntRx   = 1'b0;
    o_EnRxPwr = 1'b0;
    o_EnLna   = 1'b0;
    case (state_q)
      S_TX_GUARD, S_TX_PULSE: begin
        o_AntTx = 1'b1;
        o_EnAmp = 1'b1;
      end
      S_RX_GUARD, S_RX_WAIT, S_LISTEN, S_RESP_DELAY: begin
        o_AntRx   = 1'b1;
        o_EnRxPwr = 1'b1;
        o_EnLna   = 1'b1;
      end
      default: ;
    endcase
    o_TxPulse  = (state_q == S_TX_PULSE);
    o_TdcStart = (state_q == S_TX_PULSE);
    o_Busy     = !(state_q inside {S_IDLE, S_LISTEN, S_INIT_DAC, S_WAIT_DAC});
  end

  // raw i_Rx here keeps the TDC stop free of synchroniser delay
  assign o_TdcStop  = i_Rx & stop_arm_q;
  assign o_DacStart = dac_start_q;
  assign o_Rtt      = rtt_q;
  assign o_RttValid = rtt_valid_q;
  assign o_MeasIdx  = idx_q;
  assign o_Done     = done_q;
  assign o_Timeout  = timeout_q;
`ifdef BURST_RETRY_EN
  assign o_MissCnt  = miss_q;
`endif

endmodule

// File: tb/tb_pulse_txrx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pulse_txrx_sequencer
//   Self-checking bench for pulse_txrx_sequencer with default parameters.
//   Expected timing comes from an event-level model. Each burst or reply is
//   reduced to a handful of cycle numbers, and those are derived from the
//   pulse, guard, delay and synchroniser latencies:
//     - TX pulse start
//     - echo detect
//     - strobe cycles
//   Strobe counts are cross-checked by a free-running monitor.
// -----------------------------------------------------------------------------
module tb_pulse_txrx_sequencer;
  localparam int PULSE = 4, GUARD = 8, RESP = 8, TMO = 1000, BW = 8, CW = 16;
  localparam logic [4:0] FE_TX = 5'b10100, FE_RX = 5'b01011;

  logic          i_Clk = 1'b0, i_Rst_L = 1'b0, i_Mode = 1'b1, i_Start = 1'b0;
  logic          i_Rx = 1'b0, i_DacReady = 1'b0;
  logic [BW-1:0] i_BurstLen = '0;
  logic          o_DacStart, o_TxPulse, o_TdcStart, o_TdcStop;
  logic          o_AntTx, o_AntRx, o_EnAmp, o_EnRxPwr, o_EnLna, o_Busy;
  logic [CW-1:0] o_Rtt;
  logic          o_RttValid, o_Done, o_Timeout;
  logic [BW-1:0] o_MeasIdx;
`ifdef BURST_RETRY_EN
  logic [BW-1:0] o_MissCnt;
`endif
  logic [4:0]    fe;

  assign fe = {o_AntTx, o_AntRx, o_EnAmp, o_EnRxPwr, o_EnLna};

  pulse_txrx_sequencer dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Mode(i_Mode), .i_Start(i_Start),
    .i_BurstLen(i_BurstLen), .i_Rx(i_Rx), .i_DacReady(i_DacReady),
    .o_DacStart(o_DacStart), .o_TxPulse(o_TxPulse), .o_TdcStart(o_TdcStart),
    .o_TdcStop(o_TdcStop), .o_AntTx(o_AntTx), .o_AntRx(o_AntRx), .o_EnAmp(o_EnAmp),
    .o_EnRxPwr(o_EnRxPwr), .o_EnLna(o_EnLna), .o_Busy(o_Busy), .o_Rtt(o_Rtt),
    .o_RttValid(o_RttValid), .o_MeasIdx(o_MeasIdx), .o_Done(o_Done),
`ifdef BURST_RETRY_EN
    .o_MissCnt(o_MissCnt),
`endif
    .o_Timeout(o_Timeout)
  );

  always #5 i_Clk = ~i_Clk;

  int cyc = 0, errs = 0, checks = 0;
  int n_dac = 0, n_done = 0, n_rttv = 0, n_to = 0, n_tx = 0;
  logic tx_prev = 1'b0;
  int dly[8], wid[8];

  always @(posedge i_Clk) cyc <= cyc + 1;

  always @(negedge i_Clk) begin
    n_dac   <= n_dac  + int'(o_DacStart);
    n_done  <= n_done + int'(o_Done);
    n_rttv  <= n_rttv + int'(o_RttValid);
    n_to    <= n_to   + int'(o_Timeout);
    n_tx    <= n_tx   + int'(o_TxPulse && !tx_prev);
    tx_prev <= o_TxPulse;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk); #1;
  endtask
  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask
  task automatic smp();
    @(negedge i_Clk);
  endtask

  // request 1 cycle, DAC answers 5 cycles later, expect IDLE afterwards
  task automatic dac_bringup();
    int n0, t0, c;
    n0 = n_dac; t0 = cyc;
    while (!o_DacStart && cyc < t0 + 20) tick();
    chk("dac_start_seen", 32'(o_DacStart), 1);
    c = cyc;
    goto(c + 5); i_DacReady = 1'b1;
    tick();      i_DacReady = 1'b0;
    smp();
    chk("dac_start_once", n_dac - n0, 1);
    chk("idle_busy", 32'(o_Busy), 0);
    chk("idle_fe", 32'(fe), 0);
  endtask

  // initiator burst; dly[k] < 0 means no echo for measurement k
  task automatic burst(input int blf, input bit poke);
    int n, s, p, e, tx0, rv0, dn0, to0, etx, erv, eto;
    bit stop;
`ifdef BURST_RETRY_EN
    int miss;
    miss = 0;
`endif
    n = (blf == 0) ? 1 : blf;
    tx0 = n_tx; rv0 = n_rttv; dn0 = n_done; to0 = n_to;
    etx = 0; erv = 0; eto = 0; stop = 0; e = 0;
    i_BurstLen = BW'(blf); i_Start = 1'b1; s = cyc;
    tick(); i_Start = 1'b0;
    p = s + 1 + GUARD;
    for (int k = 0; k < n && !stop; k++) begin
      goto(p); smp();
      chk("tx_on", 32'(o_TxPulse), 1);
      chk("tdc_start", 32'(o_TdcStart), 1);
      chk("meas_idx", 32'(o_MeasIdx), k);
      chk("fe_tx", 32'(fe), 32'(FE_TX));
      etx++;
      if (poke) begin
        i_Start = 1'b1; i_BurstLen = BW'($urandom);
        tick(); i_Start = 1'b0;
      end
      goto(p + PULSE); smp();
      chk("tx_off", 32'(o_TxPulse), 0);
      chk("fe_rx", 32'(fe), 32'(FE_RX));
      if (dly[k] >= 0) begin
        goto(p + dly[k]); i_Rx = 1'b1; smp();
        chk("tdc_stop", 32'(o_TdcStop), 1);
        goto(p + dly[k] + wid[k]); i_Rx = 1'b0;
        e = p + dly[k] + 2;
        goto(e + 1); smp();
        chk("rtt_valid", 32'(o_RttValid), 1);
        chk("rtt", 32'(o_Rtt), dly[k] + 2);
        chk("no_to_on_hit", 32'(o_Timeout), 0);
        erv++;
      end else begin
        e = p + TMO - 1;
        goto(e); smp();
        chk("to_not_early", 32'(o_Timeout), 0);
        goto(e + 1); smp();
        chk("timeout", 32'(o_Timeout), 1);
        eto++;
`ifdef BURST_RETRY_EN
        miss++;
`else
        stop = 1;
`endif
      end
      p = e + 1 + GUARD;
    end
    chk("done", 32'(o_Done), stop ? 0 : 1);
    goto(cyc + 3); smp();
    chk("burst_tx_count", n_tx - tx0, etx);
    chk("burst_rttv_count", n_rttv - rv0, erv);
    chk("burst_to_count", n_to - to0, eto);
    chk("burst_done_count", n_done - dn0, stop ? 0 : 1);
    chk("burst_idle", 32'(o_Busy), 0);
`ifdef BURST_RETRY_EN
    chk("miss_cnt", 32'(o_MissCnt), miss);
`endif
  endtask

  // responder reply to a w-cycle pulse, plus a pulse inside RX_GUARD that must be ignored
  task automatic respond(input int w);
    int r, f, pp, l, tx0, dn0;
    tx0 = n_tx; dn0 = n_done;
    r = cyc + 2;
    goto(r);     i_Rx = 1'b1;
    goto(r + w); i_Rx = 1'b0;
    f  = r + w + 2;
    pp = f + 1 + RESP + GUARD;
    goto(f + 1); smp();
    chk("resp_delay_busy", 32'(o_Busy), 1);
    chk("resp_delay_fe", 32'(fe), 32'(FE_RX));
    goto(pp - 1); smp();
    chk("resp_guard_tx", {o_TxPulse, fe}, {1'b0, FE_TX});
    goto(pp); smp();
    chk("resp_tx_on", 32'(o_TxPulse), 1);
    goto(pp + PULSE - 1); smp();
    chk("resp_tx_last", 32'(o_TxPulse), 1);
    goto(pp + PULSE); smp();
    chk("resp_tx_off", 32'(o_TxPulse), 0);
    goto(pp + PULSE + 1); i_Rx = 1'b1;
    tick();               i_Rx = 1'b0;
    l = pp + PULSE + GUARD;
    goto(l); smp();
    chk("resp_done", 32'(o_Done), 1);
    chk("resp_listen_fe", {o_Busy, fe}, {1'b0, FE_RX});
    goto(l + 30); smp();
    chk("resp_tx_count", n_tx - tx0, 1);
    chk("resp_done_count", n_done - dn0, 1);
  endtask

  initial begin
    int s;
    // reset and DAC bring-up
    smp();
    chk("rst_outputs", {o_DacStart, o_TxPulse, o_TdcStop, fe, o_Busy, o_RttValid, o_Done, o_Timeout}, 0);
    tick(); tick(); i_Rst_L = 1'b1;
    dac_bringup();

    // single measurement, RTT 42
    dly[0] = 40; wid[0] = 2;
    burst(1, 0);
    // three measurements incl. minimum RTT
    dly[0] = PULSE + GUARD; dly[1] = 25; dly[2] = 60;
    wid[0] = 1; wid[1] = 2; wid[2] = 1;
    burst(3, 1);
    // echo on the timeout cycle: hit wins, RTT = TMO-1
    dly[0] = TMO - 3; wid[0] = 1;
    burst(1, 0);
    // no echoes
    dly[0] = -1; dly[1] = -1;
    burst(2, 0);

    // randomised bursts
    for (int b = 0; b < 6; b++) begin
      int blf;
      blf = $urandom_range(0, 4);
      for (int k = 0; k < 4; k++) begin
        dly[k] = $urandom_range(PULSE + GUARD, 90);
        wid[k] = $urandom_range(1, 2);
      end
      repeat ($urandom_range(0, 4)) tick();
      burst(blf, 1'($urandom_range(0, 1)));
    end

    // responder
    i_Mode = 1'b0; tick(); tick(); smp();
    chk("listen_fe", {o_Busy, fe}, {1'b0, FE_RX});
    respond(4);
    for (int t = 0; t < 3; t++) respond($urandom_range(1, 6));
    i_Start = 1'b1; tick(); i_Start = 1'b0; tick(); smp();
    chk("listen_ignores_start", {o_Busy, fe}, {1'b0, FE_RX});
    i_Mode = 1'b1; tick(); tick(); smp();
    chk("back_to_idle_fe", {o_Busy, fe}, 0);

    // async reset during TX_PULSE
    i_BurstLen = 1; i_Start = 1'b1; s = cyc;
    tick(); i_Start = 1'b0;
    goto(s + 1 + GUARD + 1); smp();
    chk("pre_rst_tx", 32'(o_TxPulse), 1);
    #1 i_Rst_L = 1'b0;
    #1;
    chk("rst_async_tx", {o_TxPulse, o_AntTx, o_EnAmp}, 0);
    chk("rst_busy", 32'(o_Busy), 0);
    chk("rst_rtt", 32'(o_Rtt), 0);
    tick(); tick(); i_Rst_L = 1'b1;
    dac_bringup();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
